read_b_out: RTL and testbench

READ_B_OUT -- requirements
Module: read_b_out

---
 rtl/bft_pkg.sv | 16 +
 rtl/read_b_out.sv | 119 +++++++++++
 tb/tb_read_b_out.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bft_pkg.sv
// Shared BFT definitions: default field widths and the drain FSM state encoding.
package bft_pkg;

  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_PAYLOAD_BITS  = 64;
  localparam int DEF_NUM_ADDR_BITS = 7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } rbo_state_t;

endpackage

// File: rtl/read_b_out.sv
// read_b_out: drains a range of words from an external BRAM and emits one
// BFT packet per word, honouring out_ack backpressure.
// Optional build macro: READ_B_OUT_SKIP_INVALID_EN -- when defined, words whose
// stored valid bit (doutb MSB) is 0 are skipped instead of being sent.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RD    | BRAM read issued at addr
// LAT   | BRAM data arrives, captured into data_q
// SEND  | packet presented, held until out_ack
// FIN   | one-cycle done pulse, then back to IDLE
module read_b_out
  import bft_pkg::*;
#(
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_ADDR_BITS = DEF_NUM_ADDR_BITS,
  parameter int PORT_No       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_ADDR_BITS-1:0] start_addr,
  input  logic [NUM_ADDR_BITS:0]   num_words,
  output logic                     enb,
  output logic [NUM_ADDR_BITS-1:0] addrb,
  input  logic [PAYLOAD_BITS:0]    doutb,
  output logic [NUM_PORT_BITS-1:0] out_port,
  output logic [NUM_ADDR_BITS-1:0] out_addr,
  output logic                     out_vld,
  output logic [PAYLOAD_BITS-1:0]  out_payload,
  input  logic                     out_ack,
  output logic                     busy,
  output logic                     done
);

  localparam logic [NUM_ADDR_BITS:0] CNT_ONE = {{NUM_ADDR_BITS{1'b0}}, 1'b1};

  rbo_state_t                 state_q, state_d;
  logic [NUM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [NUM_ADDR_BITS:0]     cnt_q, cnt_d;
  logic [PAYLOAD_BITS-1:0]    data_q, data_d;
  logic                       advance;

`ifndef READ_B_OUT_SKIP_INVALID_EN
  // Stored valid bit only matters when invalid words are skipped.
  logic unused_vld;
  assign unused_vld = doutb[PAYLOAD_BITS];
`endif

  // State, address, count and captured data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; "advance" moves to the next word after a send or skip.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = S_FIN;
          end else begin
            addr_d  = start_addr;
            cnt_d   = num_words;
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_LAT;
      S_LAT: begin
        data_d = doutb[PAYLOAD_BITS-1:0];
`ifdef READ_B_OUT_SKIP_INVALID_EN
        if (!doutb[PAYLOAD_BITS]) advance = 1'b1;
        else                      state_d = S_SEND;
`else
        state_d = S_SEND;
`endif
      end
      S_SEND: if (out_ack) advance = 1'b1;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      addr_d  = addr_q + {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};
      cnt_d   = cnt_q - CNT_ONE;
      state_d = (cnt_q > CNT_ONE) ? S_RD : S_FIN;
    end
  end

  // Outputs decoded from state; packet fields read zero when not valid.
  always_comb begin
    enb         = (state_q == S_RD);
    addrb       = (state_q == S_RD) ? addr_q : '0;
    out_vld     = (state_q == S_SEND);
    out_port    = (state_q == S_SEND) ? NUM_PORT_BITS'(PORT_No) : '0;
    out_addr    = (state_q == S_SEND) ? addr_q : '0;
    out_payload = (state_q == S_SEND) ? data_q : '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FIN);
  end

endmodule

// File: tb/tb_read_b_out.sv
// Scoreboard bench for read_b_out: expected packets are queued when a drain is
// launched; a negedge monitor pops and compares every accepted packet.
// Compile with +define+READ_B_OUT_SKIP_INVALID_EN to exercise the skip build.
module tb_read_b_out;
  import bft_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  start_addr = '0;
  logic [7:0]  num_words = '0;
  logic        enb;
  logic [6:0]  addrb;
  logic [64:0] doutb = '0;
  logic [3:0]  out_port;
  logic [6:0]  out_addr;
  logic        out_vld;
  logic [63:0] out_payload;
  logic        out_ack = 1'b0;
  logic        busy;
  logic        done;

  read_b_out dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .num_words(num_words), .enb(enb), .addrb(addrb), .doutb(doutb),
    .out_port(out_port), .out_addr(out_addr), .out_vld(out_vld),
    .out_payload(out_payload), .out_ack(out_ack), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External BRAM, one-cycle read latency. Word 61 has its valid bit cleared.
  logic [64:0] mem [128];
  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = {(i != 61), 32'hC0DE_0000 | 32'(i), 32'h5A5A_5A5A ^ 32'(i)};
  end
  always @(posedge clk) if (enb) doutb <= mem[addrb];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic [70:0] exp_q [$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: counts done pulses, scores accepted packets, checks hold stability.
  logic        held = 1'b0;
  logic [6:0]  h_addr;
  logic [63:0] h_pay;
  logic [70:0] e;
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_vld) begin
      check("out_port", out_port, 4'd2);
      if (held) begin
        check("hold_addr", out_addr, h_addr);
        check("hold_payload", out_payload, h_pay);
      end
      if (out_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pkt: addr %0d payload %0h, none expected", out_addr, out_payload);
        end else begin
          e = exp_q.pop_front();
          check("pkt_addr", out_addr, e[70:64]);
          check("pkt_payload", out_payload, e[63:0]);
        end
      end
    end else if (reset) begin
      check("idle_fields_zero", {out_port, out_addr, out_payload}, '0);
    end
    held   = out_vld && !out_ack;
    h_addr = out_addr;
    h_pay  = out_payload;
  end

  task automatic nb();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] a, input logic [63:0] p);
    exp_q.push_back({a, p});
  endtask

  // Queue expectations straight from the memory image (used for bulk ranges).
  task automatic expect_range(input logic [6:0] sa, input int n);
    logic [6:0] a;
    for (int i = 0; i < n; i++) begin
      a = sa + 7'(i);
`ifdef READ_B_OUT_SKIP_INVALID_EN
      if (mem[a][64])
`endif
        push(a, mem[a][63:0]);
    end
  endtask

  task automatic pulse_start(input logic [6:0] sa, input logic [7:0] nw);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = sa;
    num_words = nw;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic finish_drain(input string nm, input int d0, input int budget,
                              input int min_lat, input int max_lat);
    int lat;
    for (int i = 0; i < budget && done_cnt == d0; i++) nb();
    check({nm, "_done_seen"}, 128'(done_cnt != d0), 128'd1);
    lat = done_cyc - start_cyc;
    check({nm, "_latency_ok"}, 128'(lat >= min_lat && lat <= max_lat), 128'd1);
    nb();
    check({nm, "_busy_low"}, busy, 1'b0);
    check({nm, "_done_single"}, done, 1'b0);
    nb();
    check({nm, "_done_count"}, 128'(done_cnt - d0), 128'd1);
    check({nm, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  int d0;
  initial begin
    // Reset
    repeat (3) nb();
    check("rst_outputs", {enb, addrb, out_vld, out_port, out_addr, out_payload, busy, done}, '0);
    reset = 1'b1;
    nb();

    // Basic drain, ack tied high
    out_ack = 1'b1;
    push(7'd0, 64'hC0DE0000_5A5A5A5A);
    push(7'd1, 64'hC0DE0001_5A5A5A5B);
    push(7'd2, 64'hC0DE0002_5A5A5A58);
    d0 = done_cnt;
    pulse_start(7'd0, 8'd3);
    finish_drain("basic", d0, 40, 1, 11);

    // Backpressure: hold ack low for 5 cycles of out_vld
    out_ack = 1'b0;
    expect_range(7'd10, 2);
    d0 = done_cnt;
    pulse_start(7'd10, 8'd2);
    for (int i = 0; i < 10 && !out_vld; i++) nb();
    check("bp_vld_seen", out_vld, 1'b1);
    repeat (4) nb();
    check("bp_vld_held", out_vld, 1'b1);
    check("bp_none_accepted", 128'(exp_q.size()), 128'd2);
    @(posedge clk);
    #1;
    out_ack = 1'b1;
    finish_drain("bp", d0, 40, 1, 20);

    // Address wrap
    push(7'd126, 64'hC0DE007E_5A5A5A24);
    push(7'd127, 64'hC0DE007F_5A5A5A25);
    push(7'd0,   64'hC0DE0000_5A5A5A5A);
    push(7'd1,   64'hC0DE0001_5A5A5A5B);
    d0 = done_cnt;
    pulse_start(7'd126, 8'd4);
    finish_drain("wrap", d0, 40, 1, 14);

    // Zero count: done with no packet
    d0 = done_cnt;
    pulse_start(7'd33, 8'd0);
    finish_drain("zero", d0, 10, 1, 2);

    // Full count: every address once, wrapping from 5
    expect_range(7'd5, 128);
    d0 = done_cnt;
    pulse_start(7'd5, 8'd128);
    finish_drain("full", d0, 500, 1, 386);

    // Start while busy is ignored
    expect_range(7'd20, 3);
    d0 = done_cnt;
    pulse_start(7'd20, 8'd3);
    nb();
    start = 1'b1;
    start_addr = 7'd50;
    num_words = 8'd5;
    nb();
    start = 1'b0;
    finish_drain("busy_start", d0, 40, 1, 11);
    repeat (5) nb();
    check("busy_start_no_relaunch", busy, 1'b0);

    // Skip feature: word 61 stored invalid
`ifdef READ_B_OUT_SKIP_INVALID_EN
    push(7'd60, 64'hC0DE003C_5A5A5A66);
    push(7'd62, 64'hC0DE003E_5A5A5A64);
`else
    push(7'd60, 64'hC0DE003C_5A5A5A66);
    push(7'd61, 64'hC0DE003D_5A5A5A67);
    push(7'd62, 64'hC0DE003E_5A5A5A64);
`endif
    d0 = done_cnt;
    pulse_start(7'd60, 8'd3);
    finish_drain("skip", d0, 40, 1, 11);

    // Reset during SEND: no packet, no done
    out_ack = 1'b0;
    pulse_start(7'd40, 8'd3);
    for (int i = 0; i < 10 && !out_vld; i++) nb();
    check("rst_send_vld_seen", out_vld, 1'b1);
    reset = 1'b0;
    nb();
    check("rst_send_vld_low", out_vld, 1'b0);
    check("rst_send_busy_low", busy, 1'b0);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ack = 1'b1;
    repeat (20) nb();
    check("rst_send_no_done", 128'(done_cnt - d0), 128'd0);
    check("rst_send_idle", {busy, enb}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
